dac7611_serializer: RTL and testbench



---
 rtl/dac_pkg.sv | 13 +
 rtl/dac_tick_gen.sv | 28 ++
 rtl/dac7611_serializer.sv | 158 +++++++++++++++
 tb/tb_dac7611_serializer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared types and constants for the dual DAC7611 serial driver.
package dac_pkg;

  localparam int DAC_BITS      = 12;
  localparam int LE_LOW_HALVES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } dac_state_t;

endpackage

// File: rtl/dac_tick_gen.sv
// Half-period timebase for the DAC serial clock: one-cycle tick every CLK_DIV
// clk cycles, restarted by clear so a new frame begins with a full low phase.
module dac_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clear,
  output logic tick
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      div_cnt <= RELOAD;
    end else if (clear || (div_cnt == 8'd0)) begin
      div_cnt <= RELOAD;
    end else begin
      div_cnt <= div_cnt - 8'd1;
    end
  end

  assign tick = (div_cnt == 8'd0);

endmodule

// File: rtl/dac7611_serializer.sv
// Dual-channel DAC7611 serializer: one-deep pending pair, MSB-first shift on a
// shared dac_clk, shared active-low latch strobe. Build option: DAC_TWOS_COMP_EN.
module dac7611_serializer
  import dac_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic [DAC_BITS-1:0] sample_1,
  input  logic [DAC_BITS-1:0] sample_2,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                busy,
  output logic                dac_clk,
  output logic                dac_dat_1,
  output logic                dac_dat_2,
  output logic                dac_le
);

  localparam logic [3:0] LAST_BIT  = 4'(DAC_BITS - 1);
  localparam logic [3:0] LAST_HALF = 4'(LE_LOW_HALVES - 1);

  dac_state_t state, state_nx;
  logic [3:0] bit_cnt, bit_cnt_nx;
  logic       dac_clk_nx, dac_le_nx, dat_1_nx, dat_2_nx;
  logic       load, shift_out, tick, accept;
  logic       pend_empty;

  logic [DAC_BITS-1:0] pend_1, pend_2;
  logic [DAC_BITS-1:0] sh_1, sh_2;
  logic [DAC_BITS-1:0] ld_1, ld_2;

  function automatic logic [DAC_BITS-1:0] to_dac_code(input logic [DAC_BITS-1:0] w);
`ifdef DAC_TWOS_COMP_EN
    return {~w[DAC_BITS-1], w[DAC_BITS-2:0]};
`else
    return w;
`endif
  endfunction

  dac_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_b (rst_b),
    .clear (load),
    .tick  (tick)
  );

  assign accept = sample_valid && pend_empty;
  assign ld_1   = to_dac_code(pend_1);
  assign ld_2   = to_dac_code(pend_2);

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    dac_clk_nx = dac_clk;
    dac_le_nx  = dac_le;
    dat_1_nx   = dac_dat_1;
    dat_2_nx   = dac_dat_2;
    load       = 1'b0;
    shift_out  = 1'b0;

    case (state)
      IDLE: begin
        if (!pend_empty) load = 1'b1;
      end
      SHIFT: begin
        if (tick) begin
          if (!dac_clk) begin
            dac_clk_nx = 1'b1;
          end else begin
            dac_clk_nx = 1'b0;
            if (bit_cnt == LAST_BIT) begin
              dac_le_nx  = 1'b0;
              bit_cnt_nx = 4'd0;
              state_nx   = LATCH;
            end else begin
              bit_cnt_nx = bit_cnt + 4'd1;
              shift_out  = 1'b1;
            end
          end
        end
      end
      LATCH: begin
        // bit_cnt is reused here to count the strobe's low half-periods
        if (tick) begin
          if (bit_cnt == LAST_HALF) begin
            dac_le_nx = 1'b1;
            if (!pend_empty) begin
              load = 1'b1;
            end else begin
              state_nx = IDLE;
              dat_1_nx = 1'b0;
              dat_2_nx = 1'b0;
            end
          end else begin
            bit_cnt_nx = bit_cnt + 4'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    if (load) begin
      state_nx   = SHIFT;
      bit_cnt_nx = 4'd0;
      dac_clk_nx = 1'b0;
      dat_1_nx   = ld_1[DAC_BITS-1];
      dat_2_nx   = ld_2[DAC_BITS-1];
    end else if (shift_out) begin
      dat_1_nx = sh_1[DAC_BITS-1];
      dat_2_nx = sh_2[DAC_BITS-1];
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      dac_clk    <= 1'b0;
      dac_le     <= 1'b1;
      dac_dat_1  <= 1'b0;
      dac_dat_2  <= 1'b0;
      pend_empty <= 1'b1;
    end else begin
      state     <= state_nx;
      bit_cnt   <= bit_cnt_nx;
      dac_clk   <= dac_clk_nx;
      dac_le    <= dac_le_nx;
      dac_dat_1 <= dat_1_nx;
      dac_dat_2 <= dat_2_nx;
      if (accept) begin
        pend_empty <= 1'b0;
      end else if (load) begin
        pend_empty <= 1'b1;
      end
    end
  end

  // Shift registers hold the bits still to be sent, next bit at the MSB
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_1 <= sample_1;
      pend_2 <= sample_2;
    end
    if (load) begin
      sh_1 <= {ld_1[DAC_BITS-2:0], 1'b0};
      sh_2 <= {ld_2[DAC_BITS-2:0], 1'b0};
    end else if (shift_out) begin
      sh_1 <= {sh_1[DAC_BITS-2:0], 1'b0};
      sh_2 <= {sh_2[DAC_BITS-2:0], 1'b0};
    end
  end

  assign sample_ready = pend_empty;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_dac7611_serializer.sv
// Directed bench: three serializers (CLK_DIV 2, 5, 1) feeding behavioural DAC7611 models.
module tb_dac7611_serializer;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [11:0] s1 = 12'h000;
  logic [11:0] s2 = 12'h000;
  logic [2:0]  vld = 3'b000;

  logic rdy_0, rdy_1, rdy_2, bsy_0, bsy_1, bsy_2;
  logic dclk_0, dclk_1, dclk_2, d1_0, d1_1, d1_2, d2_0, d2_1, d2_2, le_0, le_1, le_2;
  logic [2:0] rdy, bsy, dclk, dd1, dd2, le;
  assign rdy  = {rdy_2, rdy_1, rdy_0};
  assign bsy  = {bsy_2, bsy_1, bsy_0};
  assign dclk = {dclk_2, dclk_1, dclk_0};
  assign dd1  = {d1_2, d1_1, d1_0};
  assign dd2  = {d2_2, d2_1, d2_0};
  assign le   = {le_2, le_1, le_0};

  always #5 clk = ~clk;

  dac7611_serializer #(.CLK_DIV(2)) dut (
    .clk(clk), .rst_b(rst_b), .sample_1(s1), .sample_2(s2), .sample_valid(vld[0]),
    .sample_ready(rdy_0), .busy(bsy_0), .dac_clk(dclk_0), .dac_dat_1(d1_0),
    .dac_dat_2(d2_0), .dac_le(le_0));

  dac7611_serializer #(.CLK_DIV(5)) dut_div5 (
    .clk(clk), .rst_b(rst_b), .sample_1(s1), .sample_2(s2), .sample_valid(vld[1]),
    .sample_ready(rdy_1), .busy(bsy_1), .dac_clk(dclk_1), .dac_dat_1(d1_1),
    .dac_dat_2(d2_1), .dac_le(le_1));

  dac7611_serializer #(.CLK_DIV(1)) dut_div1 (
    .clk(clk), .rst_b(rst_b), .sample_1(s1), .sample_2(s2), .sample_valid(vld[2]),
    .sample_ready(rdy_2), .busy(bsy_2), .dac_clk(dclk_2), .dac_dat_1(d1_2),
    .dac_dat_2(d2_2), .dac_le(le_2));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 5 : 1;
  endfunction

  function automatic logic [11:0] exp_word(input logic [11:0] w);
`ifdef DAC_TWOS_COMP_EN
    return {~w[11], w[10:0]};
`else
    return w;
`endif
  endfunction

  // Behavioural DAC7611 pair per instance plus frame timing capture
  logic [11:0] sr1 [3], sr2 [3], dreg1 [3], dreg2 [3];
  logic [11:0] lat1 [3][32], lat2 [3][32];
  int          latc [3][32], latl [3][32], latf [3][32], latr [3][32];
  int          nlat [3], rises [3], load_cyc [3], frise [3], stab [3], setup_err [3];
  logic [2:0]  pclk, ple, pbsy, pd1, pd2;

  initial begin
    for (int i = 0; i < 3; i++) begin
      nlat[i] = 0; rises[i] = 0; load_cyc[i] = 0; frise[i] = 0;
      stab[i] = 0; setup_err[i] = 0;
      sr1[i] = '0; sr2[i] = '0; dreg1[i] = '0; dreg2[i] = '0;
    end
    pclk = '0; ple = '1; pbsy = '0; pd1 = '0; pd2 = '0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if ((dd1[i] != pd1[i]) || (dd2[i] != pd2[i])) stab[i] = 0;
      else if (stab[i] < 1000) stab[i]++;
      if (!rst_b) begin
        sr1[i] = '0; sr2[i] = '0; dreg1[i] = '0; dreg2[i] = '0; rises[i] = 0;
      end else begin
        if (bsy[i] && !pbsy[i]) load_cyc[i] = cyc;
        if (dclk[i] && !pclk[i]) begin
          sr1[i] = {sr1[i][10:0], dd1[i]};
          sr2[i] = {sr2[i][10:0], dd2[i]};
          rises[i]++;
          if (rises[i] == 1) frise[i] = cyc;
          if (stab[i] < div_of(i)) setup_err[i]++;
        end
        if (le[i] && !ple[i]) begin
          dreg1[i] = sr1[i];
          dreg2[i] = sr2[i];
          if (nlat[i] < 32) begin
            lat1[i][nlat[i]] = sr1[i];
            lat2[i][nlat[i]] = sr2[i];
            latc[i][nlat[i]] = cyc;
            latl[i][nlat[i]] = load_cyc[i];
            latf[i][nlat[i]] = frise[i];
            latr[i][nlat[i]] = rises[i];
          end
          nlat[i]++;
          rises[i] = 0;
          if (bsy[i]) load_cyc[i] = cyc;
        end
      end
    end
    pclk = dclk; ple = le; pbsy = bsy; pd1 = dd1; pd2 = dd2;
  end

  task automatic send(input int i, input logic [11:0] a, input logic [11:0] b, output int hs);
    int n;
    n = 0;
    @(negedge clk);
    s1 = a; s2 = b; vld[i] = 1'b1;
    while (!rdy[i] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    hs = cyc;
    vld[i] = 1'b0;
  endtask

  task automatic wait_lat(input int i, input int n);
    int k;
    k = 0;
    while (nlat[i] < n && k < 6000) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("latch_count", 32'(nlat[i]), 32'(n));
  endtask

  task automatic check_outputs_reset(input string tag);
    chk({tag, "_dac_clk"}, 32'(dclk_0), 32'd0);
    chk({tag, "_dat_1"},   32'(d1_0),   32'd0);
    chk({tag, "_dat_2"},   32'(d2_0),   32'd0);
    chk({tag, "_le"},      32'(le_0),   32'd1);
    chk({tag, "_ready"},   32'(rdy_0),  32'd1);
    chk({tag, "_busy"},    32'(bsy_0),  32'd0);
  endtask

  logic [11:0] pa [8], pb [8];
  int hs [8];
  int h;

  initial begin
    pa[0] = 12'h001; pb[0] = 12'hFFE;
    pa[1] = 12'h123; pb[1] = 12'h456;
    pa[2] = 12'h800; pb[2] = 12'h7FF;
    pa[3] = 12'hFFF; pb[3] = 12'h000;
    pa[4] = 12'hA5A; pb[4] = 12'h5A5;
    pa[5] = 12'h3C3; pb[5] = 12'hC3C;
    pa[6] = 12'h7FE; pb[6] = 12'h801;
    pa[7] = 12'h0F0; pb[7] = 12'hF0F;

    repeat (3) @(posedge clk);
    #1;
    check_outputs_reset("reset");
    rst_b = 1'b1;
    repeat (2) @(posedge clk);

    // single pair, CLK_DIV = 2
    send(0, 12'h925, 12'h466, h);
    chk("single_ready_drop", 32'(rdy_0), 32'd0);
    wait_lat(0, 1);
    chk("single_w1", 32'(lat1[0][0]), 32'(exp_word(12'h925)));
    chk("single_w2", 32'(lat2[0][0]), 32'(exp_word(12'h466)));
    chk("single_rises", 32'(latr[0][0]), 32'd12);
    chk("single_load_lat", 32'(latl[0][0] - h), 32'd1);
    chk("single_first_rise", 32'(latf[0][0] - latl[0][0]), 32'd2);
    chk("single_frame_len", 32'(latc[0][0] - latl[0][0]), 32'd52);
    chk("single_dac_reg1", 32'(dreg1[0]), 32'(exp_word(12'h925)));

    // eight pairs offered as fast as ready allows
    for (int k = 0; k < 8; k++) begin
      send(0, pa[k], pb[k], hs[k]);
      chk("burst_ready_drop", 32'(rdy_0), 32'd0);
    end
    wait_lat(0, 9);
    chk("burst_second_accept", 32'(hs[1] - hs[0]), 32'd2);
    chk("burst_third_held", 32'(hs[2]), 32'(latc[0][1] + 1));
    chk("burst_first_frame", 32'(latc[0][1] - hs[0]), 32'd53);
    for (int k = 0; k < 8; k++) begin
      chk("burst_w1", 32'(lat1[0][k+1]), 32'(exp_word(pa[k])));
      chk("burst_w2", 32'(lat2[0][k+1]), 32'(exp_word(pb[k])));
      chk("burst_rises", 32'(latr[0][k+1]), 32'd12);
      if (k > 0) chk("burst_period", 32'(latc[0][k+1] - latc[0][k]), 32'd52);
    end

    // reset in the middle of a frame
    repeat (3) @(posedge clk);
    send(0, 12'hABC, 12'h123, h);
    begin
      int k;
      k = 0;
      while (rises[0] < 6 && k < 500) begin
        @(negedge clk);
        #1;
        k++;
      end
      chk("mid_reach_bit6", 32'(rises[0]), 32'd6);
    end
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    #1;
    check_outputs_reset("midreset");
    @(negedge clk);
    #1;
    chk("midreset_dac1", 32'(dreg1[0]), 32'd0);
    chk("midreset_dac2", 32'(dreg2[0]), 32'd0);
    chk("midreset_no_latch", 32'(nlat[0]), 32'd9);
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
    send(0, 12'h800, 12'h800, h);
    wait_lat(0, 10);
    chk("post_reset_w1", 32'(lat1[0][9]), 32'(exp_word(12'h800)));
    chk("post_reset_w2", 32'(lat2[0][9]), 32'(exp_word(12'h800)));
    chk("post_reset_rises", 32'(latr[0][9]), 32'd12);

    // extreme codes (two's complement conversion when enabled)
    send(0, 12'h000, 12'hFFF, h);
    wait_lat(0, 11);
    chk("code_w1", 32'(lat1[0][10]), 32'(exp_word(12'h000)));
    chk("code_w2", 32'(lat2[0][10]), 32'(exp_word(12'hFFF)));

    // CLK_DIV = 5
    send(1, 12'h5A3, 12'h0C7, h);
    wait_lat(1, 1);
    chk("div5_w1", 32'(lat1[1][0]), 32'(exp_word(12'h5A3)));
    chk("div5_w2", 32'(lat2[1][0]), 32'(exp_word(12'h0C7)));
    chk("div5_rises", 32'(latr[1][0]), 32'd12);
    chk("div5_first_rise", 32'(latf[1][0] - latl[1][0]), 32'd5);
    chk("div5_frame_len", 32'(latc[1][0] - latl[1][0]), 32'd130);

    // CLK_DIV = 1
    send(2, 12'hFFF, 12'h001, h);
    wait_lat(2, 1);
    chk("div1_w1", 32'(lat1[2][0]), 32'(exp_word(12'hFFF)));
    chk("div1_w2", 32'(lat2[2][0]), 32'(exp_word(12'h001)));
    chk("div1_rises", 32'(latr[2][0]), 32'd12);
    chk("div1_first_rise", 32'(latf[2][0] - latl[2][0]), 32'd1);
    chk("div1_frame_len", 32'(latc[2][0] - latl[2][0]), 32'd26);

    for (int i = 0; i < 3; i++) chk("setup_violations", 32'(setup_err[i]), 32'd0);
    chk("idle_after", 32'(bsy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
